stage_2_decode: RTL and testbench
=================================

Name: stage_2_decode

Overview:
Instruction-decode stage of the 5-stage RV32I pipeline. Sits directly downstream of the if_id register and upstream of id_ex. Holds the 32x32 integer register file, decodes the fetched instruction into control and immediate fields, and detects load-use hazards to stall fetch. The registered outputs feed id_ex, so a decoded instruction appears one clock after it is presented.

Parameters:
XLEN, 32, datapath width
NUM_REGS, 32, register-file depth; x0 is hardwired to zero
NOP_INSTR, 32'h00000013, encoding (addi x0,x0,0) reported on instr_out for bubbles

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
i_pc  in  32  PC from if_id
i_instr  in  32  instruction from if_id
i_valid  in  1  if_id holds a real instruction
flush  in  1  branch/jump taken in EX; kill the instruction in decode
ex_mem_read  in  1  instruction now in EX is a load
ex_rd  in  5  destination register of the instruction in EX
wb_we  in  1  writeback enable
wb_rd  in  5  writeback destination
wb_data  in  32  writeback value
stall  out  1  combinational; hold stage_1 PC and if_id contents
pc  out  32  registered PC
instr_out  out  32  registered instruction (NOP_INSTR on bubble)
rs1_val, rs2_val  out  32 each  registered operand values
imm  out  32  registered sign-extended immediate
rs1, rs2, rd  out  5 each  registered register indices
alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
alu_src  out  1  1 selects imm as ALU operand B
mem_read, mem_write, reg_write, branch, jump  out  1 each  control bits
valid  out  1  registered valid flag
illegal  out  1  registered; opcode/funct combination not in RV32I base set

Behaviour:
- Reset (asynchronous): all registered outputs go to 0 except instr_out, which goes to NOP_INSTR. All registers x1..x31 clear to 0. stall is 0 while rst is high.
- Register file: write on the rising edge when wb_we=1 and wb_rd!=0. Writes to x0 are dropped. Reads are combinational; x0 always reads 0.
- Immediate: formats I, S, B, U, J follow the RV32I spec. Immediates are sign-extended from the instruction's bit 31. For B and J, bit 0 is 0. R-type produces imm=0.
- Source use: rs1 is used by all opcodes except LUI, AUIPC and JAL. rs2 is used by R, S and B types only.
- Hazard: stall = i_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==rs1 & rs1 used) | (ex_rd==rs2 & rs2 used)) & ~flush.
- Output register update priority on each rising edge:
  1. flush=1: load a bubble (valid=0, all control bits 0, instr_out=NOP_INSTR, illegal=0). flush overrides stall.
  2. stall=1: load a bubble. if_id holds, so the same instruction is decoded again next cycle.
  3. i_valid=0: load a bubble.
  4. Otherwise: load the decoded fields with valid=1.
- Illegal instruction: valid=1, illegal=1, and all control bits forced to 0, so the instruction has no side effects. Flagging it is left to later stages.
- JAL/JALR: jump=1, reg_write=1, alu_op=PASS_B. Consumers compute PC+4 for the link value. LUI: alu_op=PASS_B, alu_src=1.
- Latency: one clock from i_instr to the outputs. Throughput is one instruction per clock when there is no stall.
- Reset mid-stall: stall drops immediately and the pipeline restarts from a bubble.

Optional Feature:
WB_BYPASS_EN. When defined, a read of a register that is being written in the same cycle (wb_we=1, wb_rd==rs, rs!=0) returns wb_data, i.e. write-before-read. When undefined, the read returns the old contents and the forwarding unit must cover this case. The default build defines it.

Test Plan:
- Reset: assert rst mid-clock, then read all outputs -> valid=0, instr_out=32'h00000013, stall=0; every register reads 0 after release.
- Writeback then read: wb x5=32'hDEADBEEF; then decode add x6,x5,x0 -> next cycle rs1_val=32'hDEADBEEF, rs2_val=0, alu_op=0, reg_write=1. Also write x0=5 -> x0 still reads 0.
- Same-cycle bypass: wb x7=32'h12345678 in the same cycle as decoding addi x8,x7,-1 -> with WB_BYPASS_EN, rs1_val=32'h12345678 and imm=32'hFFFFFFFF. Without the macro, rs1_val holds the old value.
- Load-use: ex_mem_read=1, ex_rd=3; decode sub x4,x3,x2 -> stall=1 and a bubble is registered. Drop ex_mem_read -> stall=0 and the sub decodes with alu_op=1. Repeat with ex_rd=0 -> no stall.
- Flush over stall: flush=1 together with a hazard condition -> stall=0, bubble out, valid=0.
- Immediates: instruction 32'hFE000EE3 (beq x0,x0,-4) -> imm=32'hFFFFFFFC, branch=1. Instruction 32'h800000EF (jal x1,-1MiB) -> imm=32'hFFF00000, jump=1, rd=1. Opcode 7'b1111111 -> illegal=1, valid=1, all control bits 0.

Source files
------------

// File: rtl/stage_2_decode.sv
// ---------------------------------------------------------------------------
// stage_2_decode -- RV32I instruction-decode stage.
//
// Holds the 32 x XLEN integer register file, decodes the instruction held in
// if_id into control bits, register indices and a sign-extended immediate,
// and raises a combinational stall on a load-use hazard against the
// instruction in EX. All decoded fields are registered toward id_ex, so a
// decoded instruction appears on the outputs one clock after it is presented.
//
// Optional feature: define WB_BYPASS_EN to return wb_data for a register
// that is being written back in the same cycle it is read (write-before-read).
// Without it the old register contents are read and forwarding must cover it.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_pc, i_instr      PC / instruction from if_id
//   i_valid            if_id holds a real instruction
//   flush              kill the instruction in decode (branch/jump taken)
//   ex_mem_read, ex_rd load-in-EX indication and its destination
//   wb_we, wb_rd,
//   wb_data            register-file write port
//   stall              combinational; hold fetch PC and if_id
//   pc, instr_out      registered PC / instruction (NOP_INSTR on a bubble)
//   rs1_val, rs2_val   registered operand values
//   imm                registered sign-extended immediate
//   rs1, rs2, rd       registered register indices
//   alu_op, alu_src    ALU operation, 1 = immediate as operand B
//   mem_read, mem_write, reg_write, branch, jump   control bits
//   valid, illegal     registered valid / illegal-instruction flags
// ---------------------------------------------------------------------------
module stage_2_decode #(
  parameter int          XLEN      = 32,
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     i_pc,
  input  logic [31:0]     i_instr,
  input  logic            i_valid,
  input  logic            flush,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic [31:0]     pc,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            branch,
  output logic            jump,
  output logic            valid,
  output logic            illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign opcode  = i_instr[6:0];
  assign funct3  = i_instr[14:12];
  assign funct7  = i_instr[31:25];
  assign rs1_idx = i_instr[19:15];
  assign rs2_idx = i_instr[24:20];
  assign rd_idx  = i_instr[11:7];

  // -------------------------------------------------------------------------
  // Register file. Entry 0 is a flop that is never written, so it reads 0
  // without a special case in the read path.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] regs [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regs[gi] <= '0;
      end else if (wb_we && (wb_rd == 5'(gi)) && (gi != 0)) begin
        regs[gi] <= wb_data;
      end
    end
  end

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  always_comb begin
    rs1_data = regs[rs1_idx];
    rs2_data = regs[rs2_idx];
`ifdef WB_BYPASS_EN
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_idx)) rs1_data = wb_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_idx)) rs2_data = wb_data;
`endif
  end

  // -------------------------------------------------------------------------
  // Immediate formats, all sign-extended from instruction bit 31.
  // -------------------------------------------------------------------------
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                  i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'h000};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                  i_instr[30:21], 1'b0};

  // ALU op shared by OP and OP-IMM; alt selects SUB/SRA.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic [31:0] d_imm;
  logic [3:0]  d_alu;
  logic        d_src, d_mr, d_mw, d_rw, d_br, d_jp, d_legal;
  logic        rs1_used, rs2_used;

  always_comb begin
    d_imm    = '0;
    d_alu    = ALU_ADD;
    d_src    = 1'b0;
    d_mr     = 1'b0;
    d_mw     = 1'b0;
    d_rw     = 1'b0;
    d_br     = 1'b0;
    d_jp     = 1'b0;
    d_legal  = 1'b0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_LUI: begin
        d_imm = imm_u; d_alu = ALU_PASS_B; d_src = 1'b1; d_rw = 1'b1;
        d_legal = 1'b1; rs1_used = 1'b0;
      end
      OP_AUIPC: begin
        d_imm = imm_u; d_src = 1'b1; d_rw = 1'b1;
        d_legal = 1'b1; rs1_used = 1'b0;
      end
      OP_JAL: begin
        d_imm = imm_j; d_alu = ALU_PASS_B; d_src = 1'b1; d_rw = 1'b1; d_jp = 1'b1;
        d_legal = 1'b1; rs1_used = 1'b0;
      end
      OP_JALR: begin
        d_imm = imm_i; d_alu = ALU_PASS_B; d_src = 1'b1; d_rw = 1'b1; d_jp = 1'b1;
        d_legal = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        d_imm = imm_b; d_br = 1'b1; rs2_used = 1'b1;
        d_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        // beq/bne compare by subtraction, blt/bge and bltu/bgeu by set-less-than
        case (funct3[2:1])
          2'b10:   d_alu = ALU_SLT;
          2'b11:   d_alu = ALU_SLTU;
          default: d_alu = ALU_SUB;
        endcase
      end
      OP_LOAD: begin
        d_imm = imm_i; d_src = 1'b1; d_mr = 1'b1; d_rw = 1'b1;
        d_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OP_STORE: begin
        d_imm = imm_s; d_src = 1'b1; d_mw = 1'b1; rs2_used = 1'b1;
        d_legal = funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OP_IMM: begin
        d_imm = imm_i; d_src = 1'b1; d_rw = 1'b1;
        // Only the shift-right immediate uses funct7 to pick SRA.
        d_alu = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  d_legal = (funct7 == 7'b0000000);
          3'b101:  d_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: d_legal = 1'b1;
        endcase
      end
      OP_REG: begin
        d_rw = 1'b1; rs2_used = 1'b1;
        d_alu = alu_from_f3(funct3, funct7[5]);
        d_legal = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_FENCE: begin
        d_imm = imm_i;
        d_legal = (funct3 == 3'b000);
      end
      OP_SYSTEM: begin
        // Only ECALL (all zero above the opcode) and EBREAK are accepted.
        d_imm = imm_i;
        d_legal = (i_instr[31:7] == 25'h0000000) || (i_instr[31:7] == 25'h0002000);
      end
      default: begin
        d_legal = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load-use hazard. Forced low while in reset so fetch is released at once.
  // -------------------------------------------------------------------------
  assign stall = ~rst & i_valid & ex_mem_read & (ex_rd != 5'd0) &
                 (((ex_rd == rs1_idx) & rs1_used) | ((ex_rd == rs2_idx) & rs2_used)) &
                 ~flush;

  // -------------------------------------------------------------------------
  // id_ex-facing output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0; instr_out <= NOP_INSTR; rs1_val <= '0; rs2_val <= '0; imm <= '0;
      rs1 <= '0; rs2 <= '0; rd <= '0; alu_op <= ALU_ADD; alu_src <= 1'b0;
      mem_read <= 1'b0; mem_write <= 1'b0; reg_write <= 1'b0;
      branch <= 1'b0; jump <= 1'b0; valid <= 1'b0; illegal <= 1'b0;
    end else if (flush || stall || !i_valid) begin
      pc <= '0; instr_out <= NOP_INSTR; rs1_val <= '0; rs2_val <= '0; imm <= '0;
      rs1 <= '0; rs2 <= '0; rd <= '0; alu_op <= ALU_ADD; alu_src <= 1'b0;
      mem_read <= 1'b0; mem_write <= 1'b0; reg_write <= 1'b0;
      branch <= 1'b0; jump <= 1'b0; valid <= 1'b0; illegal <= 1'b0;
    end else begin
      pc        <= i_pc;
      instr_out <= i_instr;
      rs1_val   <= rs1_data;
      rs2_val   <= rs2_data;
      imm       <= d_imm;
      rs1       <= rs1_idx;
      rs2       <= rs2_idx;
      rd        <= rd_idx;
      valid     <= 1'b1;
      illegal   <= ~d_legal;
      // An illegal instruction travels on with every control bit cleared.
      alu_op    <= d_legal ? d_alu : ALU_ADD;
      alu_src   <= d_legal & d_src;
      mem_read  <= d_legal & d_mr;
      mem_write <= d_legal & d_mw;
      reg_write <= d_legal & d_rw;
      branch    <= d_legal & d_br;
      jump      <= d_legal & d_jp;
    end
  end

endmodule

// File: tb/tb_stage_2_decode.sv
// ---------------------------------------------------------------------------
// tb_stage_2_decode -- self-checking bench for stage_2_decode.
// A reference model built from an RV32I mask/match instruction table and a
// plain register array predicts every registered output and the stall line;
// a compare process checks the DUT against it on each falling edge. Directed
// cases with hand-computed values pin the model, then randomized traffic runs.
// ---------------------------------------------------------------------------
module tb_stage_2_decode;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_pc, i_instr, wb_data;
  logic        i_valid, flush, ex_mem_read, wb_we;
  logic [4:0]  ex_rd, wb_rd;

  logic        stall;
  logic [31:0] pc, instr_out, rs1_val, rs2_val, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, reg_write, branch, jump, valid, illegal;

  stage_2_decode dut (
    .clk(clk), .rst(rst), .i_pc(i_pc), .i_instr(i_instr), .i_valid(i_valid),
    .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .pc(pc), .instr_out(instr_out),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .branch(branch), .jump(jump), .valid(valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc, instr, rs1_val, rs2_val, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, branch, jump, valid, illegal;
  } out_t;

  // ctl = {alu_src, mem_read, mem_write, reg_write, branch, jump}
  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  alu;
    logic [5:0]  ctl;
  } ent_t;

  ent_t        tab[$];
  logic [31:0] m_regs [32];
  out_t        exp_q;

  function automatic void add(input logic [31:0] mask, input logic [31:0] match,
                              input logic [3:0] alu, input logic [5:0] ctl);
    ent_t e;
    e.mask = mask; e.match = match; e.alu = alu; e.ctl = ctl;
    tab.push_back(e);
  endfunction

  function automatic void build_table();
    // OP
    add(32'hFE00707F, 32'h00000033, 4'd0, 6'b000100);
    add(32'hFE00707F, 32'h40000033, 4'd1, 6'b000100);
    add(32'hFE00707F, 32'h00001033, 4'd2, 6'b000100);
    add(32'hFE00707F, 32'h00002033, 4'd3, 6'b000100);
    add(32'hFE00707F, 32'h00003033, 4'd4, 6'b000100);
    add(32'hFE00707F, 32'h00004033, 4'd5, 6'b000100);
    add(32'hFE00707F, 32'h00005033, 4'd6, 6'b000100);
    add(32'hFE00707F, 32'h40005033, 4'd7, 6'b000100);
    add(32'hFE00707F, 32'h00006033, 4'd8, 6'b000100);
    add(32'hFE00707F, 32'h00007033, 4'd9, 6'b000100);
    // OP-IMM
    add(32'h0000707F, 32'h00000013, 4'd0, 6'b100100);
    add(32'h0000707F, 32'h00002013, 4'd3, 6'b100100);
    add(32'h0000707F, 32'h00003013, 4'd4, 6'b100100);
    add(32'h0000707F, 32'h00004013, 4'd5, 6'b100100);
    add(32'h0000707F, 32'h00006013, 4'd8, 6'b100100);
    add(32'h0000707F, 32'h00007013, 4'd9, 6'b100100);
    add(32'hFE00707F, 32'h00001013, 4'd2, 6'b100100);
    add(32'hFE00707F, 32'h00005013, 4'd6, 6'b100100);
    add(32'hFE00707F, 32'h40005013, 4'd7, 6'b100100);
    // loads, stores
    add(32'h0000707F, 32'h00000003, 4'd0, 6'b110100);
    add(32'h0000707F, 32'h00001003, 4'd0, 6'b110100);
    add(32'h0000707F, 32'h00002003, 4'd0, 6'b110100);
    add(32'h0000707F, 32'h00004003, 4'd0, 6'b110100);
    add(32'h0000707F, 32'h00005003, 4'd0, 6'b110100);
    add(32'h0000707F, 32'h00000023, 4'd0, 6'b101000);
    add(32'h0000707F, 32'h00001023, 4'd0, 6'b101000);
    add(32'h0000707F, 32'h00002023, 4'd0, 6'b101000);
    // branches
    add(32'h0000707F, 32'h00000063, 4'd1, 6'b000010);
    add(32'h0000707F, 32'h00001063, 4'd1, 6'b000010);
    add(32'h0000707F, 32'h00004063, 4'd3, 6'b000010);
    add(32'h0000707F, 32'h00005063, 4'd3, 6'b000010);
    add(32'h0000707F, 32'h00006063, 4'd4, 6'b000010);
    add(32'h0000707F, 32'h00007063, 4'd4, 6'b000010);
    // jumps, upper immediates, fence, ecall/ebreak
    add(32'h0000707F, 32'h00000067, 4'd10, 6'b100101);
    add(32'h0000007F, 32'h0000006F, 4'd10, 6'b100101);
    add(32'h0000007F, 32'h00000037, 4'd10, 6'b100100);
    add(32'h0000007F, 32'h00000017, 4'd0,  6'b100100);
    add(32'h0000707F, 32'h0000000F, 4'd0,  6'b000000);
    add(32'hFFFFFFFF, 32'h00000073, 4'd0,  6'b000000);
    add(32'hFFFFFFFF, 32'h00100073, 4'd0,  6'b000000);
  endfunction

  // Immediate by opcode class, built arithmetically from shifted words.
  function automatic logic [31:0] imm_of(input logic [31:0] w);
    logic [31:0] iv, sv;
    iv = $signed(w) >>> 20;
    sv = (iv & ~32'h1F) | 32'(w[11:7]);
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: return iv;
      7'h23: return sv;
      7'h63: return ((32'($signed(w) >>> 19)) & 32'hFFFFF000) | (32'(w[30:25]) << 5) |
                    (32'(w[11:8]) << 1) | (32'(w[7]) << 11);
      7'h37, 7'h17: return w & 32'hFFFFF000;
      7'h6F: return ((32'($signed(w) >>> 11)) & 32'hFFF00000) | (w & 32'h000FF000) |
                    (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic out_t bubble();
    out_t b = '0;
    b.instr = NOP;
    return b;
  endfunction

  function automatic out_t model_out(input logic [31:0] w, input logic [31:0] pcv,
                                     input logic [31:0] r1, input logic [31:0] r2);
    out_t o = '0;
    bit   hit = 1'b0;
    o.pc = pcv; o.instr = w; o.rs1_val = r1; o.rs2_val = r2; o.imm = imm_of(w);
    o.rs1 = w[19:15]; o.rs2 = w[24:20]; o.rd = w[11:7];
    o.valid = 1'b1; o.illegal = 1'b1;
    foreach (tab[k]) begin
      if (!hit && ((w & tab[k].mask) == tab[k].match)) begin
        hit = 1'b1;
        o.illegal = 1'b0;
        o.alu_op = tab[k].alu;
        {o.alu_src, o.mem_read, o.mem_write, o.reg_write, o.branch, o.jump} = tab[k].ctl;
      end
    end
    return o;
  endfunction

  function automatic bit model_stall();
    logic [6:0] op = i_instr[6:0];
    bit u1 = !(op inside {7'h37, 7'h17, 7'h6F});
    bit u2 = op inside {7'h33, 7'h23, 7'h63};
    return !rst && i_valid && ex_mem_read && (ex_rd != 5'd0) && !flush &&
           (((ex_rd == i_instr[19:15]) && u1) || ((ex_rd == i_instr[24:20]) && u2));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      exp_q = bubble();
    end else begin
      logic [31:0] r1, r2;
      r1 = m_regs[i_instr[19:15]];
      r2 = m_regs[i_instr[24:20]];
`ifdef WB_BYPASS_EN
      if (wb_we && wb_rd != 5'd0 && wb_rd == i_instr[19:15]) r1 = wb_data;
      if (wb_we && wb_rd != 5'd0 && wb_rd == i_instr[24:20]) r2 = wb_data;
`endif
      if (flush || model_stall() || !i_valid) exp_q = bubble();
      else exp_q = model_out(i_instr, i_pc, r1, r2);
      if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",        pc,                exp_q.pc);
      check("instr_out", instr_out,         exp_q.instr);
      check("rs1_val",   rs1_val,           exp_q.rs1_val);
      check("rs2_val",   rs2_val,           exp_q.rs2_val);
      check("imm",       imm,               exp_q.imm);
      check("rs1",       32'(rs1),          32'(exp_q.rs1));
      check("rs2",       32'(rs2),          32'(exp_q.rs2));
      check("rd",        32'(rd),           32'(exp_q.rd));
      check("alu_op",    32'(alu_op),       32'(exp_q.alu_op));
      check("alu_src",   32'(alu_src),      32'(exp_q.alu_src));
      check("mem_read",  32'(mem_read),     32'(exp_q.mem_read));
      check("mem_write", 32'(mem_write),    32'(exp_q.mem_write));
      check("reg_write", 32'(reg_write),    32'(exp_q.reg_write));
      check("branch",    32'(branch),       32'(exp_q.branch));
      check("jump",      32'(jump),         32'(exp_q.jump));
      check("valid",     32'(valid),        32'(exp_q.valid));
      check("illegal",   32'(illegal),      32'(exp_q.illegal));
      check("stall",     32'(stall),        32'(model_stall()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [31:0] w);
    i_instr = w;
    i_valid = 1'b1;
    i_pc    = i_pc + 32'd4;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    build_table();
    i_pc = 32'h0; i_instr = NOP; i_valid = 1'b0; flush = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_instr", instr_out, 32'h00000013);
    check("rst_stall", 32'(stall), 32'h0);
    rst = 1'b0;
    tick();

    // writeback x5, then add x6,x5,x0
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; i_valid = 1'b0;
    tick();
    wb_we = 1'b0;
    dec(32'h00028333);
    tick();
    check("wb_rs1", rs1_val, 32'hDEADBEEF);
    check("wb_rs2", rs2_val, 32'h0);
    check("wb_alu", 32'(alu_op), 32'd0);
    check("wb_rw",  32'(reg_write), 32'd1);

    // write x0 is dropped
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd5; i_valid = 1'b0;
    tick();
    wb_we = 1'b0;
    dec(32'h00000333);
    tick();
    check("x0_zero", rs1_val, 32'h0);

    // same-cycle writeback of x7 while decoding addi x8,x7,-1
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678;
    dec(32'hFFF38413);
    tick();
    wb_we = 1'b0;
    check("byp_imm", imm, 32'hFFFFFFFF);
`ifdef WB_BYPASS_EN
    check("byp_rs1", rs1_val, 32'h12345678);
`else
    check("byp_rs1", rs1_val, 32'h00000000);
`endif
    tick();
    check("after_wb_rs1", rs1_val, 32'h12345678);

    // load-use on sub x4,x3,x2
    ex_mem_read = 1'b1; ex_rd = 5'd3;
    dec(32'h40218233);
    #1 check("lu_stall", 32'(stall), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(valid), 32'd0);
    check("lu_bubble_instr", instr_out, 32'h00000013);
    ex_mem_read = 1'b0;
    #1 check("lu_release", 32'(stall), 32'd0);
    tick();
    check("lu_valid", 32'(valid), 32'd1);
    check("lu_alu",   32'(alu_op), 32'd1);
    ex_mem_read = 1'b1; ex_rd = 5'd0;
    #1 check("lu_x0_stall", 32'(stall), 32'd0);
    tick();
    check("lu_x0_valid", 32'(valid), 32'd1);

    // flush beats stall
    ex_rd = 5'd3; flush = 1'b1;
    #1 check("fl_stall", 32'(stall), 32'd0);
    tick();
    check("fl_valid", 32'(valid), 32'd0);
    check("fl_instr", instr_out, 32'h00000013);
    flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;

    // immediates and special opcodes
    dec(32'hFE000EE3);
    tick();
    check("beq_imm", imm, 32'hFFFFFFFC);
    check("beq_br",  32'(branch), 32'd1);
    dec(32'h800000EF);
    tick();
    check("jal_imm", imm, 32'hFFF00000);
    check("jal_jp",  32'(jump), 32'd1);
    check("jal_rd",  32'(rd), 32'd1);
    dec(32'h123450B7);
    tick();
    check("lui_imm", imm, 32'h12345000);
    check("lui_alu", 32'(alu_op), 32'd10);
    check("lui_src", 32'(alu_src), 32'd1);
    dec(32'h0000007F);
    tick();
    check("ill_flag",  32'(illegal), 32'd1);
    check("ill_valid", 32'(valid), 32'd1);
    check("ill_ctl",   32'({mem_read, mem_write, reg_write, branch, jump}), 32'd0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] w;
      ent_t e;
      if ($urandom_range(7) == 0) begin
        w = $urandom;
      end else begin
        e = tab[$urandom_range(tab.size() - 1)];
        w = ($urandom & ~e.mask) | e.match;
      end
      i_instr     = w;
      i_pc        = $urandom & 32'hFFFFFFFC;
      i_valid     = ($urandom_range(9) != 0);
      flush       = ($urandom_range(9) == 0);
      ex_mem_read = ($urandom_range(2) == 0);
      case ($urandom_range(2))
        0:       ex_rd = w[19:15];
        1:       ex_rd = w[24:20];
        default: ex_rd = 5'($urandom);
      endcase
      wb_we   = ($urandom_range(1) == 1);
      wb_rd   = ($urandom_range(2) == 0) ? w[19:15] : 5'($urandom);
      wb_data = $urandom;
      tick();
    end

    // reset asserted mid-cycle during a load-use stall
    wb_we = 1'b0; flush = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd3;
    dec(32'h40218233);
    #1 check("mid_pre_stall", 32'(stall), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_stall", 32'(stall), 32'd0);
    check("mid_valid", 32'(valid), 32'd0);
    check("mid_instr", instr_out, 32'h00000013);
    @(posedge clk);
    #1 rst = 1'b0;
    ex_mem_read = 1'b0;
    for (int r = 1; r < 32; r++) begin
      logic [31:0] w;
      w = (32'(r) << 20) | (32'(r) << 15) | 32'h33;
      dec(w);
      tick();
      check("clr_rs1", rs1_val, 32'h0);
      check("clr_rs2", rs2_val, 32'h0);
    end

    i_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
